// File: rtl/rv32_mem_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// rv32_mem_responder : single-outstanding memory target with byte-lane writes
//                      and a programmable number of response wait states.
// Rev 1.0
//------------------------------------------------------------------------------
module rv32_mem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_we,
    input  logic [3:0]  i_req_be,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);
    localparam int         DEPTH       = 2**ADDR_WIDTH;
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  r_armed;
    logic [31:0]           r_addr;
    logic                  r_we;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_enter_resp;
    logic                  w_accept;
    logic [31:0]           w_addr;
    logic                  w_we;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [32:0]           w_offset;
    logic                  w_err;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_idx;

    // With zero wait states the access commits on the accept edge itself,
    // so the live request is used while still in IDLE.
    assign w_addr   = (r_state == S_IDLE) ? i_req_addr  : r_addr;
    assign w_we     = (r_state == S_IDLE) ? i_req_we    : r_we;
    assign w_be     = (r_state == S_IDLE) ? i_req_be    : r_be;
    assign w_wdata  = (r_state == S_IDLE) ? i_req_wdata : r_wdata;

    assign w_offset = {1'b0, w_addr} - {1'b0, BASE_ADDR};
    assign w_err    = (w_addr[1:0] != 2'b00) || w_offset[32] ||
                      (w_offset[31:ADDR_WIDTH+2] != '0);
    assign w_idx    = w_offset[ADDR_WIDTH+1:2];
    assign w_accept = i_req_valid && o_req_ready;
    assign w_wr_en  = w_enter_resp && w_we && !w_err;

    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        o_req_ready  = 1'b0;
        o_rsp_valid  = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = r_armed;
                if (i_req_valid && r_armed) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_armed <= 1'b0;
            r_addr  <= 32'd0;
            r_we    <= 1'b0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_armed <= 1'b1;
            if (w_accept) begin
                r_addr  <= i_req_addr;
                r_we    <= i_req_we;
                r_be    <= i_req_be;
                r_wdata <= i_req_wdata;
            end
            if (w_enter_resp) begin
                r_rdata <= (w_err || w_we) ? 32'd0 : r_mem[w_idx];
                r_err   <= w_err;
            end else if ((r_state == S_RESP) && i_rsp_ready) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b0;
            end
        end
    end

    // Array contents survive reset; only committed, in-range writes touch it.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32_mem_responder.sv
`default_nettype none
// tb_rv32_mem_responder : scoreboard bench over three responders with
// 1, 0 and 15 wait states sharing one request bus.
module tb_rv32_mem_responder;
    localparam logic [31:0] c_BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = 4'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_ready = 1'b1;

    logic [2:0]  dv;
    logic [2:0]  drr;
    logic [2:0]  drv;
    logic [2:0]  derr;
    logic [31:0] drd [3];

    logic        req_ready_m;
    logic        rsp_valid_m;
    logic        rsp_err_m;
    logic [31:0] rsp_rdata_m;

    always #5 clk = ~clk;

    assign dv = req_valid ? (3'b001 << sel) : 3'b000;

    always_comb begin
        req_ready_m = drr[sel];
        rsp_valid_m = drv[sel];
        rsp_err_m   = derr[sel];
        rsp_rdata_m = drd[sel];
    end

    rv32_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(c_BASE), .WAIT_STATES(1)) u_dut_w1 (
        .clk(clk), .reset_n(reset_n), .i_req_valid(dv[0]), .o_req_ready(drr[0]),
        .i_req_addr(req_addr), .i_req_we(req_we), .i_req_be(req_be), .i_req_wdata(req_wdata),
        .o_rsp_valid(drv[0]), .i_rsp_ready(rsp_ready), .o_rsp_rdata(drd[0]), .o_rsp_err(derr[0]));

    rv32_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(c_BASE), .WAIT_STATES(0)) u_dut_w0 (
        .clk(clk), .reset_n(reset_n), .i_req_valid(dv[1]), .o_req_ready(drr[1]),
        .i_req_addr(req_addr), .i_req_we(req_we), .i_req_be(req_be), .i_req_wdata(req_wdata),
        .o_rsp_valid(drv[1]), .i_rsp_ready(rsp_ready), .o_rsp_rdata(drd[1]), .o_rsp_err(derr[1]));

    rv32_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(c_BASE), .WAIT_STATES(15)) u_dut_w15 (
        .clk(clk), .reset_n(reset_n), .i_req_valid(dv[2]), .o_req_ready(drr[2]),
        .i_req_addr(req_addr), .i_req_we(req_we), .i_req_be(req_be), .i_req_wdata(req_wdata),
        .o_rsp_valid(drv[2]), .i_rsp_ready(rsp_ready), .o_rsp_rdata(drd[2]), .o_rsp_err(derr[2]));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_t = 0;
    int   rise_t = 0;
    logic prev_v = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    function automatic int lat_of(input logic [1:0] s);
        case (s)
            2'd0:    return 2;
            2'd1:    return 1;
            default: return 16;
        endcase
    endfunction

    // Monitor: timestamps accepts and response rises, pops on each handshake.
    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (req_valid && req_ready_m) acc_t = cyc;
        if (rsp_valid_m && !prev_v) rise_t = cyc;
        prev_v = rsp_valid_m;
        if (rsp_valid_m && rsp_ready) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_response");
            end else begin
                e = sb.pop_front();
                chk({e.name, "_rdata"},   rsp_rdata_m,       e.rdata);
                chk({e.name, "_err"},     32'(rsp_err_m),    32'(e.err));
                chk({e.name, "_latency"}, 32'(rise_t - acc_t), 32'(e.lat));
            end
        end
    end

    task automatic xact(input logic [1:0] s, input logic [31:0] a, input logic we,
                        input logic [3:0] be, input logic [31:0] wd, input logic [31:0] erd,
                        input logic eerr, input int bp, input string nm);
        int n;
        @(posedge clk); #1;
        sel = s; req_addr = a; req_we = we; req_be = be; req_wdata = wd;
        req_valid = 1'b1;
        rsp_ready = (bp == 0);
        sb.push_back('{erd, eerr, lat_of(s), nm});
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready_m && n < 50);
        if (!req_ready_m) begin
            void'(sb.pop_back());
            req_valid = 1'b0;
            fail_now({nm, "_accept"});
            return;
        end
        @(posedge clk); #1;
        // Garbage on the request bus after the accept must be ignored.
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_we = ~we; req_be = 4'hF; req_wdata = ~wd;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid_m && n < 50);
        if (!rsp_valid_m) begin
            void'(sb.pop_back());
            rsp_ready = 1'b1;
            fail_now({nm, "_rsp_valid"});
            return;
        end
        if (bp > 0) begin
            for (int i = 0; i < bp; i++) begin
                chk({nm, "_hold_valid"}, 32'(rsp_valid_m), 32'd1);
                chk({nm, "_hold_rdata"}, rsp_rdata_m, erd);
                chk({nm, "_hold_err"},   32'(rsp_err_m), 32'(eerr));
                chk({nm, "_hold_ready"}, 32'(req_ready_m), 32'd0);
                @(negedge clk);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(negedge clk);
            chk({nm, "_hs_ready"}, 32'(req_ready_m), 32'd0);
        end
    endtask

    initial begin
        // Reset with a request pending
        sel = 2'd0; req_valid = 1'b1; reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready_m), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_m), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_m, 32'd0);
        chk("rst_rsp_err",   32'(rsp_err_m), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_ready", 32'(req_ready_m), 32'd1);

        // One wait state: basic write/read
        xact(2'd0, c_BASE + 32'h4,   1'b1, 4'hF, 32'hDEAD_BEEF, 32'd0,          1'b0, 0, "wr_w1");
        xact(2'd0, c_BASE + 32'h4,   1'b0, 4'h0, 32'd0,         32'hDEAD_BEEF,  1'b0, 0, "rd_w1");
        // Byte lanes
        xact(2'd0, c_BASE + 32'h8,   1'b1, 4'hF, 32'h1122_3344, 32'd0,          1'b0, 0, "wr_lane_init");
        xact(2'd0, c_BASE + 32'h8,   1'b1, 4'h5, 32'hAABB_CCDD, 32'd0,          1'b0, 0, "wr_lane_0101");
        xact(2'd0, c_BASE + 32'h8,   1'b0, 4'h0, 32'd0,         32'h11BB_33DD,  1'b0, 0, "rd_lane");
        xact(2'd0, c_BASE + 32'h8,   1'b1, 4'h0, 32'hFFFF_FFFF, 32'd0,          1'b0, 0, "wr_be0");
        xact(2'd0, c_BASE + 32'h8,   1'b0, 4'h0, 32'd0,         32'h11BB_33DD,  1'b0, 0, "rd_after_be0");
        // Errors
        xact(2'd0, c_BASE,           1'b1, 4'hF, 32'hCAFE_F00D, 32'd0,          1'b0, 0, "wr_word0");
        xact(2'd0, c_BASE + 32'h2,   1'b0, 4'h0, 32'd0,         32'd0,          1'b1, 0, "rd_misaligned");
        xact(2'd0, c_BASE + 32'h1000, 1'b1, 4'hF, 32'h5555_5555, 32'd0,         1'b1, 0, "wr_past_end");
        xact(2'd0, c_BASE,           1'b0, 4'h0, 32'd0,         32'hCAFE_F00D,  1'b0, 0, "rd_word0_intact");
        xact(2'd0, c_BASE + 32'h4,   1'b0, 4'h0, 32'd0,         32'hDEAD_BEEF,  1'b0, 0, "rd_word1_intact");
        xact(2'd0, 32'h0FFF_FFFC,    1'b0, 4'h0, 32'd0,         32'd0,          1'b1, 0, "rd_below_base");
        // Last in-range word
        xact(2'd0, c_BASE + 32'hFFC, 1'b1, 4'hF, 32'h0BAD_F00D, 32'd0,          1'b0, 0, "wr_last");
        xact(2'd0, c_BASE + 32'hFFC, 1'b0, 4'h0, 32'd0,         32'h0BAD_F00D,  1'b0, 0, "rd_last");
        // Backpressure
        xact(2'd0, c_BASE + 32'h4,   1'b0, 4'h0, 32'd0,         32'hDEAD_BEEF,  1'b0, 5, "rd_bp");
        xact(2'd0, c_BASE + 32'hC,   1'b1, 4'hF, 32'h7777_0000, 32'd0,          1'b1 ^ 1'b1, 3, "wr_bp");

        // Zero wait states
        xact(2'd1, c_BASE + 32'h10,  1'b1, 4'hF, 32'h1234_5678, 32'd0,          1'b0, 0, "wr_w0");
        xact(2'd1, c_BASE + 32'h10,  1'b0, 4'h0, 32'd0,         32'h1234_5678,  1'b0, 0, "rd_w0");
        xact(2'd1, c_BASE + 32'h11,  1'b0, 4'h0, 32'd0,         32'd0,          1'b1, 0, "rd_w0_misaligned");

        // Fifteen wait states, then a write interrupted by reset
        xact(2'd2, c_BASE + 32'hC,   1'b1, 4'hF, 32'h0303_0303, 32'd0,          1'b0, 0, "wr_w15");
        xact(2'd2, c_BASE + 32'hC,   1'b0, 4'h0, 32'd0,         32'h0303_0303,  1'b0, 0, "rd_w15");
        @(posedge clk); #1;
        sel = 2'd2; req_addr = c_BASE + 32'hC; req_we = 1'b1; req_be = 4'hF;
        req_wdata = 32'hFFFF_0000; req_valid = 1'b1;
        @(negedge clk);
        chk("rstwait_accept_ready", 32'(req_ready_m), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstwait_rsp_valid", 32'(rsp_valid_m), 32'd0);
        chk("rstwait_req_ready", 32'(req_ready_m), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rstwait_idle_ready", 32'(req_ready_m), 32'd1);
        repeat (20) @(negedge clk);
        chk("rstwait_no_rsp", 32'(rsp_valid_m), 32'd0);
        xact(2'd2, c_BASE + 32'hC,   1'b0, 4'h0, 32'd0,         32'h0303_0303,  1'b0, 0, "rd_w15_after_rst");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
